hs_burst_master: RTL

HS_BURST_MASTER -- requirements
Module: hs_burst_master

---
 rtl/link_pkg.sv | 22 ++
 rtl/hs_ack_timer.sv | 29 ++
 rtl/hs_burst_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared types and defaults for the four-phase burst master and its ack timer.
package link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      REQ_HI,
      ACK_LO,
      DONE,
      ERR
   } state_t;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_MAX_LEN     = 4;
   localparam int DEF_TIMEOUT_CYC = 16;

   // Length field must hold 0..max_len inclusive.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/hs_ack_timer.sv
// Per-phase handshake watchdog: clear restarts, enable counts, expired flags the last cycle.
module hs_ack_timer
   import link_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] cnt;

   assign expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/hs_burst_master.sv
// Four-phase req/ack burst master fetching one upstream word per handshake.
// Optional handshake watchdog enabled with `define ACK_TIMEOUT_EN.
module hs_burst_master
   import link_pkg::*;
#(
   parameter int  DATA_W      = DEF_DATA_W,
   parameter int  MAX_LEN     = DEF_MAX_LEN,
   parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int LEN_W       = len_w(MAX_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_rd,
   input  logic              ack,
   output logic              req,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  word_idx
);

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_sat;
   logic             last_word;

   assign len_sat   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   assign last_word = ((word_idx + LEN_W'(1)) == len_q);

`ifdef ACK_TIMEOUT_EN
   logic tmr_clear;
   logic tmr_enable;
   logic tmr_expired;

   // Restart on every entry into a waiting phase.
   assign tmr_clear  = (state == LOAD) || ((state == REQ_HI) && ack);
   assign tmr_enable = (state == REQ_HI) || (state == ACK_LO);

   hs_ack_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         word_idx <= '0;
         data     <= '0;
         src_rd   <= 1'b0;
         req      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         err      <= 1'b0;
`endif
      end else begin
         src_rd <= 1'b0;
         done   <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         err    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= len_sat;
                  word_idx <= '0;
                  busy     <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= LOAD;
                     src_rd <= 1'b1;
                  end
               end
            end
            LOAD: begin
               data  <= src_data;
               req   <= 1'b1;
               state <= REQ_HI;
            end
            REQ_HI: begin
               if (ack) begin
                  req   <= 1'b0;
                  state <= ACK_LO;
               end
`ifdef ACK_TIMEOUT_EN
               else if (tmr_expired) begin
                  req   <= 1'b0;
                  err   <= 1'b1;
                  state <= ERR;
               end
`endif
            end
            ACK_LO: begin
               if (!ack) begin
                  if (last_word) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     word_idx <= word_idx + LEN_W'(1);
                     src_rd   <= 1'b1;
                     state    <= LOAD;
                  end
               end
`ifdef ACK_TIMEOUT_EN
               else if (tmr_expired) begin
                  err   <= 1'b1;
                  state <= ERR;
               end
`endif
            end
            DONE, ERR: begin
               busy  <= 1'b0;
               data  <= '0;
               state <= IDLE;
            end
            default: begin
               req   <= 1'b0;
               busy  <= 1'b0;
               data  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
